// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared constants for the multicycle MIPS controller: 4-bit state codes,
// primary opcodes, and the mux/ALU select codes the controller drives.
// Also defines the control-word struct and a helper that identifies states
// which complete (retire) an instruction.
// -----------------------------------------------------------------------------
package mc_pkg;

    // FSM state encodings (legacy-compatible numeric values)
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_JAL    = 4'd12;
    localparam logic [3:0] S_TRAP   = 4'd13;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] ALUB_B     = 2'b00;
    localparam logic [1:0] ALUB_FOUR  = 2'b01;
    localparam logic [1:0] ALUB_IMM   = 2'b10;
    localparam logic [1:0] ALUB_IMMSH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Register write-data select
    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;
    localparam logic [1:0] MTR_PC     = 2'b10;

    // Register write-address select
    localparam logic [1:0] RDST_RT  = 2'b00;
    localparam logic [1:0] RDST_RD  = 2'b01;
    localparam logic [1:0] RDST_R31 = 2'b10;

    // Full set of datapath controls driven in one state
    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic [1:0] memtoreg;
        logic [1:0] regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{default: '0};

    // True for the last state of every legal instruction; leaving one of
    // these for FETCH retires an instruction.
    function automatic logic is_retire_state(input logic [3:0] s);
        case (s)
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH,
            S_ADDIWB, S_JUMP, S_JAL: is_retire_state = 1'b1;
            default:                 is_retire_state = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Moore FSM sequencing a shared-memory, shared-ALU multicycle MIPS datapath
// (R-type, lw, sw, beq, addi, j, jal). Controls are decoded from the state
// register; irwrite/pcwrite in FETCH additionally follow the memory ready
// handshake. Counts retired instructions and traps on illegal opcodes.
//
// Parameters:
//   CNT_W        width of the retired-instruction counter (wraps)
//   ILLEGAL_TRAP 1: illegal opcode parks in TRAP until reset
//                0: illegal opcode returns to FETCH as an uncounted NOP
//
// Configuration macro:
//   MC_MEM_HANDSHAKE_EN  defined: FETCH/MEMRD/MEMWR wait for mem_ready
//                        undefined: mem_ready ignored, memory states take
//                        exactly one cycle
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   op[5:0]            IR opcode field, valid from DECODE onward
//   mem_ready          memory completes the current access this cycle
//   pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
//   memtoreg[1:0], regdst[1:0], regwrite, alusrca, alusrcb[1:0],
//   aluop[1:0], pcsource[1:0]      datapath controls
//   illegal            high while in TRAP
//   state[3:0]         current state (debug)
//   instr_count        retired-instruction count
// -----------------------------------------------------------------------------
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter bit          ILLEGAL_TRAP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             pcwritecond,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic [1:0]       memtoreg,
    output logic [1:0]       regdst,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic [1:0]       pcsource,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    logic [3:0]       state_r;
    logic [3:0]       next_state_s;
    logic [CNT_W-1:0] count_r;
    logic             ready_s;
    ctrl_t            ctrl_s;

`ifdef MC_MEM_HANDSHAKE_EN
    assign ready_s = mem_ready;
`else
    // Without the handshake every access completes in one cycle; the OR keeps
    // the port referenced while forcing the effective ready high.
    assign ready_s = mem_ready | 1'b1;
`endif

    // State register: async reset abandons any in-flight instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH: begin
                if (ready_s) next_state_s = S_DECODE;
                else         next_state_s = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_RTYPE:     next_state_s = S_EXEC;
                    OP_BEQ:       next_state_s = S_BRANCH;
                    OP_ADDI:      next_state_s = S_ADDIEX;
                    OP_J:         next_state_s = S_JUMP;
                    OP_JAL:       next_state_s = S_JAL;
                    default: begin
                        if (ILLEGAL_TRAP) next_state_s = S_TRAP;
                        else              next_state_s = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW) next_state_s = S_MEMRD;
                else             next_state_s = S_MEMWR;
            end
            S_MEMRD: begin
                if (ready_s) next_state_s = S_MEMWB;
                else         next_state_s = S_MEMRD;
            end
            S_MEMWB:  next_state_s = S_FETCH;
            S_MEMWR: begin
                if (ready_s) next_state_s = S_FETCH;
                else         next_state_s = S_MEMWR;
            end
            S_EXEC:   next_state_s = S_ALUWB;
            S_ALUWB:  next_state_s = S_FETCH;
            S_BRANCH: next_state_s = S_FETCH;
            S_ADDIEX: next_state_s = S_ADDIWB;
            S_ADDIWB: next_state_s = S_FETCH;
            S_JUMP:   next_state_s = S_FETCH;
            S_JAL:    next_state_s = S_FETCH;
            S_TRAP:   next_state_s = S_TRAP;
            default:  next_state_s = S_FETCH;
        endcase
    end

    // Retired-instruction counter: bumps only when a completing state hands
    // back to FETCH, so illegal-as-NOP and unused encodings are not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if ((next_state_s == S_FETCH) && is_retire_state(state_r)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Control decode from the current state.
    always_comb begin
        ctrl_s = CTRL_IDLE;
        case (state_r)
            S_FETCH: begin
                ctrl_s.memread = 1'b1;
                ctrl_s.alusrcb = ALUB_FOUR;
                // IR and PC load only once the fetch data is actually present.
                ctrl_s.irwrite = ready_s;
                ctrl_s.pcwrite = ready_s;
            end
            S_DECODE: begin
                ctrl_s.alusrcb = ALUB_IMMSH;
            end
            S_MEMADR: begin
                ctrl_s.alusrca = 1'b1;
                ctrl_s.alusrcb = ALUB_IMM;
            end
            S_MEMRD: begin
                ctrl_s.memread = 1'b1;
                ctrl_s.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl_s.regwrite = 1'b1;
                ctrl_s.regdst   = RDST_RT;
                ctrl_s.memtoreg = MTR_MDR;
            end
            S_MEMWR: begin
                ctrl_s.memwrite = 1'b1;
                ctrl_s.iord     = 1'b1;
            end
            S_EXEC: begin
                ctrl_s.alusrca = 1'b1;
                ctrl_s.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_s.regwrite = 1'b1;
                ctrl_s.regdst   = RDST_RD;
            end
            S_BRANCH: begin
                ctrl_s.alusrca     = 1'b1;
                ctrl_s.aluop       = ALUOP_SUB;
                ctrl_s.pcwritecond = 1'b1;
                ctrl_s.pcsource    = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                ctrl_s.alusrca = 1'b1;
                ctrl_s.alusrcb = ALUB_IMM;
            end
            S_ADDIWB: begin
                ctrl_s.regwrite = 1'b1;
                ctrl_s.regdst   = RDST_RT;
            end
            S_JUMP: begin
                ctrl_s.pcwrite  = 1'b1;
                ctrl_s.pcsource = PCSRC_JUMP;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value.
                ctrl_s.pcwrite  = 1'b1;
                ctrl_s.pcsource = PCSRC_JUMP;
                ctrl_s.regwrite = 1'b1;
                ctrl_s.regdst   = RDST_R31;
                ctrl_s.memtoreg = MTR_PC;
            end
            S_TRAP: begin
                ctrl_s.illegal = 1'b1;
            end
            default: begin
                ctrl_s = CTRL_IDLE;
            end
        endcase
    end

    assign pcwrite     = ctrl_s.pcwrite;
    assign pcwritecond = ctrl_s.pcwritecond;
    assign iord        = ctrl_s.iord;
    assign memread     = ctrl_s.memread;
    assign memwrite    = ctrl_s.memwrite;
    assign irwrite     = ctrl_s.irwrite;
    assign memtoreg    = ctrl_s.memtoreg;
    assign regdst      = ctrl_s.regdst;
    assign regwrite    = ctrl_s.regwrite;
    assign alusrca     = ctrl_s.alusrca;
    assign alusrcb     = ctrl_s.alusrcb;
    assign aluop       = ctrl_s.aluop;
    assign pcsource    = ctrl_s.pcsource;
    assign illegal     = ctrl_s.illegal;
    assign state       = state_r;
    assign instr_count = count_r;

endmodule
